// File: rtl/pipeline_fifo_buffer_pkg.sv
// Shared types for the pipeline FIFO buffer: one decoded handshake operation per cycle.
package pipeline_fifo_buffer_pkg;

    typedef enum logic [1:0] {
        OP_IDLE     = 2'b00,
        OP_PUSH     = 2'b01,
        OP_POP      = 2'b10,
        OP_PUSH_POP = 2'b11
    } op_t;

    function automatic op_t decode_op(input logic wr, input logic rd);
        return op_t'({rd, wr});
    endfunction

endpackage

// File: rtl/pipeline_fifo_buffer_pointer_wrap_counter.sv
// Modulo-N index counter; wraps MODULO-1 -> 0 explicitly so MODULO need not be a power of 2.
module pointer_wrap_counter #(
    parameter int WIDTH  = 2,
    parameter int MODULO = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

    always_ff @(posedge clock) begin
        if (clear) begin
            value <= '0;
        end else if (increment) begin
            value <= (value == LAST) ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_fifo_buffer_register.sv
// Loadable register with synchronous active-high clear to zero.
module clear_register #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_fifo_buffer.sv
// DEPTH-entry ready/valid FIFO, 1 word/cycle, no input->output combinational path,
// optional circular mode where a write into a full buffer replaces the oldest word.
module pipeline_fifo_buffer
    import pipeline_fifo_buffer_pkg::*;
#(
    parameter int WORD_WIDTH      = 8,
    parameter int DEPTH           = 4,
    parameter int CIRCULAR_BUFFER = 0
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         input_valid,
    output logic                         input_ready,
    input  logic [WORD_WIDTH-1:0]        input_data,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic [WORD_WIDTH-1:0]        output_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         dropped
);

    localparam int ADDR_WIDTH  = $clog2(DEPTH);
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic [WORD_WIDTH-1:0]  storage [DEPTH];
    logic [DEPTH-1:0]       entry_load;
    logic [ADDR_WIDTH-1:0]  read_ptr;
    logic [ADDR_WIDTH-1:0]  write_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   count_load;
    logic                   read_advance;
    logic                   write_advance;
    logic                   drop_next;
    logic                   wr;
    logic                   rd;

    // NOTE: storage entries are cleared too, so output_data is a defined 0 after clear rather than stale data.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        clear_register #(.WIDTH(WORD_WIDTH)) u_entry (
            .clock (clock),
            .clear (clear),
            .load  (entry_load[i]),
            .d     (input_data),
            .q     (storage[i])
        );
    end

    clear_register #(.WIDTH(COUNT_WIDTH)) u_count (
        .clock (clock),
        .clear (clear),
        .load  (count_load),
        .d     (count_next),
        .q     (count)
    );

    clear_register #(.WIDTH(1)) u_dropped (
        .clock (clock),
        .clear (clear),
        .load  (1'b1),
        .d     (drop_next),
        .q     (dropped)
    );

    pointer_wrap_counter #(.WIDTH(ADDR_WIDTH), .MODULO(DEPTH)) u_read_ptr (
        .clock     (clock),
        .clear     (clear),
        .increment (read_advance),
        .value     (read_ptr)
    );

    pointer_wrap_counter #(.WIDTH(ADDR_WIDTH), .MODULO(DEPTH)) u_write_ptr (
        .clock     (clock),
        .clear     (clear),
        .increment (write_advance),
        .value     (write_ptr)
    );

    // Handshake flags come only from registered count, keeping both sides timing-isolated.
    assign input_ready  = (count != FULL_COUNT) || (CIRCULAR_BUFFER != 0);
    assign output_valid = (count != '0);
    assign wr           = input_valid & input_ready;
    assign rd           = output_valid & output_ready;
    assign output_data  = storage[read_ptr];
    assign occupancy    = count;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        entry_load    = '0;
        count_load    = 1'b0;
        count_next    = count;
        read_advance  = 1'b0;
        write_advance = 1'b0;
        drop_next     = 1'b0;
        unique case (decode_op(wr, rd))
            OP_IDLE: ;
            OP_PUSH: begin
                entry_load[write_ptr] = 1'b1;
                write_advance         = 1'b1;
                if (count == FULL_COUNT) begin
                    // Circular overwrite: write_ptr == read_ptr, so the oldest word is retired.
                    read_advance = 1'b1;
                    drop_next    = 1'b1;
                end else begin
                    count_load = 1'b1;
                    count_next = count + COUNT_WIDTH'(1);
                end
            end
            OP_POP: begin
                read_advance = 1'b1;
                count_load   = 1'b1;
                count_next   = count - COUNT_WIDTH'(1);
            end
            OP_PUSH_POP: begin
                entry_load[write_ptr] = 1'b1;
                write_advance         = 1'b1;
                read_advance          = 1'b1;
            end
        endcase
    end

endmodule
